mult_accum_stage: RTL and testbench
===================================

Name: mult_accum_stage

Overview:
- Downstream consumer of the 4-stage pipelined multiplier (3 register stages, PRODUCT valid 3 cycles after operands are sampled).
- Carries valid, last and TC tags through a delay line matched to the multiplier latency.
- Accumulates aligned PRODUCT values into frame sums and returns each frame sum through a 2-entry ready/valid output buffer.
- Issues credit-based in_ready upstream so that the non-stallable multiplier pipeline never overruns the buffer.

Parameters:
- A_width, 8, multiplier A operand width.
- B_width, 8, multiplier B operand width.
- ACC_width, 24, accumulator/result width; must be >= A_width+B_width.
- LATENCY, 3, multiplier register stages (operand sample to PRODUCT valid); must be >= 1.
- FIFO_DEPTH, 2, output buffer entries; must be >= 1.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents A/B to the multiplier this cycle.
- in_last  in  1  beat closes the current frame.
- in_TC  in  1  TC value driven to the multiplier this beat; 1 = signed.
- in_ready  out  1  issue permitted; issue = in_valid && in_ready.
- PRODUCT  in  A_width+B_width  multiplier output.
- ACC  out  ACC_width  frame sum at the output buffer head.
- ACC_ovf  out  1  overflow/saturation occurred in the frame at the head.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.

Behaviour:
- Reset (async assert, sync deassert in the sense that registers release on the next CLK):
  - tag pipe cleared;
  - accumulator = 0, first-beat flag = 1;
  - buffer empty, so out_valid = 0, ACC = 0, ACC_ovf = 0;
  - in_ready = 1.
- Reset mid-frame discards all in-flight tags and partial sums; the multiplier contents are ignored because their tags are gone.
- Tag pipe: LATENCY-deep shift register of {v, last, tc}, loaded with {issue, in_last, in_TC} every cycle. Non-issue cycles load bubbles (v = 0).
- Alignment: when the stage-LATENCY tag has v = 1, PRODUCT belongs to that tag in that cycle.
- Extension: ext = tc ? sign-extend(PRODUCT) : zero-extend(PRODUCT), to ACC_width+1 bits.
- Accumulate: sum = (first ? 0 : acc) + ext, where acc is sign-extended if tc, else zero-extended.
- Overflow, evaluated per beat using that beat's tc:
  - signed (tc = 1): sum outside [-2^(ACC_width-1), 2^(ACC_width-1)-1];
  - unsigned (tc = 0): carry out of ACC_width.
- Frame overflow flag is sticky across the frame and cleared at frame start.
- Non-last aligned beat: acc <= sum[ACC_width-1:0], first <= 0.
- Last aligned beat:
  - push {sum[ACC_width-1:0], sticky|ovf} into the buffer;
  - acc <= 0, first <= 1, sticky <= 0.
- Single-beat frame (last on first beat) gives ACC = ext.
- Credits:
  - lasts_in_flight = count of tag stages with v && last;
  - pending = buffer_count + lasts_in_flight;
  - in_ready = (pending < FIFO_DEPTH), combinational from registered state only.
  - This guarantees a push never finds the buffer full.
- Buffer:
  - FIFO ordering; pop when out_valid && out_ready.
  - Push and pop in the same cycle is allowed, including when full (count unchanged) and when empty-with-push (data visible next cycle, no bypass).
- Output hold: ACC and ACC_ovf stay stable while out_valid && !out_ready.
- Latency: the last beat issued at cycle t gives out_valid at t+LATENCY+1 if the buffer is empty.
- Throughput: 1 beat/cycle while the consumer drains.

Optional Feature:
- Macro MULT_ACCUM_SAT_EN.
- Defined: overflowing sums clamp.
  - signed: to 2^(ACC_width-1)-1 or -2^(ACC_width-1) by direction;
  - unsigned: to 2^ACC_width-1;
  - ACC_ovf is set as usual.
- Undefined: sums wrap modulo 2^ACC_width; ACC_ovf is still reported.

Decomposition:
- Package mult_accum_pkg:
  - tag typedef {v, last, tc};
  - result typedef {acc, ovf};
  - localparam P_width = A_width+B_width;
  - saturation-limit helper functions.
- Sub-module mult_accum_fifo: parameterised synchronous FIFO of result entries with count output and the same CLK/rst_n. The top level holds the tag pipe, the accumulator and credit logic.

Test Plan:
- Unsigned frame: 3 beats with PRODUCT 10, 20, 30 (TC = 0), last on beat 3 -> one output, ACC = 60, ACC_ovf = 0; out_valid rises 4 cycles after the last issue.
- Signed frame: TC = 1, PRODUCT 0xFFF6 (-10) then 0x0005, last -> ACC = 0xFFFFFB (-5), ACC_ovf = 0.
- Overflow, ACC_width = 16, unsigned: 2 beats of 0xFFFF ->
  - with MULT_ACCUM_SAT_EN: ACC = 0xFFFF;
  - without: ACC = 0xFFFE;
  - ACC_ovf = 1 in both cases.
- Backpressure: out_ready = 0, issue 1-beat frames every cycle -> in_ready drops once pending = 2; exactly 2 entries are buffered with no loss. Set out_ready = 1 -> entries appear in order and in_ready recovers.
- Simultaneous push/pop with the buffer full and out_ready = 1 while a last beat aligns -> count stays 2 and ordering is preserved.
- Assert rst_n mid-frame with 2 beats in flight -> outputs clear immediately; after release, a new 1-beat frame with PRODUCT 7 gives ACC = 7.

Source files
------------

// File: rtl/mult_accum_pkg.sv
// Shared types and saturation-limit helpers for the multiply-accumulate stage.
package mult_accum_pkg;

  // Product width of the default 8x8 multiplier configuration.
  localparam int P_width = 16;
  localparam int SAT_W   = 64;

  typedef struct packed {
    logic v;
    logic last;
    logic tc;
  } tag_t;

  function automatic logic [SAT_W-1:0] sat_umax(input int w);
    return (SAT_W'(1) << w) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_smax(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  // Low w bits hold the most negative w-bit two's-complement value.
  function automatic logic [SAT_W-1:0] sat_smin(input int w);
    return SAT_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/mult_accum_fifo.sv
// Synchronous FIFO of frame results; data_o reads as zero while empty.
module mult_accum_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en, rd_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign wr_en   = push_i && ((count_q != CW'(DEPTH)) || pop_i);
  assign rd_en   = pop_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;

  // NOTE: storage has no reset; valid_o and the zeroed data_o hide stale words.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_q <= next_ptr(wr_q);
      if (rd_en) rd_q <= next_ptr(rd_q);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mult_accum_stage.sv
// Frame accumulator behind a LATENCY-stage multiplier with credit-based in_ready.
// Define MULT_ACCUM_SAT_EN to clamp overflowing sums instead of wrapping them.
module mult_accum_stage
  import mult_accum_pkg::*;
#(
  parameter int A_width    = 8,
  parameter int B_width    = 8,
  parameter int ACC_width  = 24,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic                       in_TC,
  output logic                       in_ready,
  input  logic [A_width+B_width-1:0] PRODUCT,
  output logic [ACC_width-1:0]       ACC,
  output logic                       ACC_ovf,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int PW  = A_width + B_width;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PCW = $clog2(LATENCY + FIFO_DEPTH + 1);
`ifdef MULT_ACCUM_SAT_EN
  localparam logic [ACC_width-1:0] U_MAX = ACC_width'(sat_umax(ACC_width));
  localparam logic [ACC_width-1:0] S_MAX = ACC_width'(sat_smax(ACC_width));
  localparam logic [ACC_width-1:0] S_MIN = ACC_width'(sat_smin(ACC_width));
`endif

  typedef struct packed {
    logic [ACC_width-1:0] acc;
    logic                 ovf;
  } result_t;

  tag_t                 tag_q [LATENCY];
  tag_t                 head;
  logic                 issue;
  logic [ACC_width-1:0] acc_q, acc_d;
  logic                 first_q, first_d;
  logic                 sticky_q, sticky_d;
  logic [ACC_width:0]   ext, base, sum;
  logic                 beat_ovf;
  logic [ACC_width-1:0] beat_res;
  logic                 push, pop;
  result_t              push_data, head_data;
  logic [CW-1:0]        fifo_count;
  logic [PCW-1:0]       pending;

  assign issue = in_valid && in_ready;
  assign head  = tag_q[LATENCY-1];

  // Both operands are extended to ACC_width+1 bits, so the sum itself never wraps.
  always_comb begin
    ext      = {{(ACC_width + 1 - PW){head.tc & PRODUCT[PW-1]}}, PRODUCT};
    base     = first_q ? '0 : {head.tc & acc_q[ACC_width-1], acc_q};
    sum      = base + ext;
    beat_ovf = head.tc ? (sum[ACC_width] ^ sum[ACC_width-1]) : sum[ACC_width];
`ifdef MULT_ACCUM_SAT_EN
    if (!beat_ovf)    beat_res = sum[ACC_width-1:0];
    else if (head.tc) beat_res = sum[ACC_width] ? S_MIN : S_MAX;
    else              beat_res = U_MAX;
`else
    beat_res = sum[ACC_width-1:0];
`endif
  end

  assign push      = head.v && head.last;
  assign push_data = '{acc: beat_res, ovf: sticky_q | beat_ovf};

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    acc_d    = acc_q;
    first_d  = first_q;
    sticky_d = sticky_q;
    if (head.v) begin
      if (head.last) begin
        acc_d    = '0;
        first_d  = 1'b1;
        sticky_d = 1'b0;
      end else begin
        acc_d    = beat_res;
        first_d  = 1'b0;
        sticky_d = sticky_q | beat_ovf;
      end
    end
  end

  // Every frame end already in the tag pipe holds a buffer slot in reserve.
  always_comb begin
    pending = PCW'(fifo_count);
    for (int i = 0; i < LATENCY; i++) begin
      pending = pending + PCW'(tag_q[i].v & tag_q[i].last);
    end
    in_ready = (pending < PCW'(FIFO_DEPTH));
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      acc_q    <= '0;
      first_q  <= 1'b1;
      sticky_q <= 1'b0;
    end else begin
      tag_q[0] <= '{v: issue, last: issue & in_last, tc: in_TC};
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
      acc_q    <= acc_d;
      first_q  <= first_d;
      sticky_q <= sticky_d;
    end
  end

  assign pop = out_valid && out_ready;

  mult_accum_fifo #(
    .WIDTH ($bits(result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign ACC     = head_data.acc;
  assign ACC_ovf = head_data.ovf;

endmodule

// File: tb/tb_mult_accum_stage.sv
// Drives a 24-bit and a 16-bit accumulator with identical beats and scores both
// against an arithmetic frame model; the bench also plays the 3-stage multiplier.
module tb_mult_accum_stage;
  import mult_accum_pkg::*;

  localparam int LAT = 3;
  localparam int PW  = P_width;

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  logic          CLK = 1'b0;
  logic          rst_n, in_valid, in_last, in_TC, out_ready;
  logic [PW-1:0] PRODUCT;
  logic          in_ready_a, out_valid_a, ovf_a;
  logic          in_ready_b, out_valid_b, ovf_b;
  logic [23:0]   acc_a;
  logic [15:0]   acc_b;

  int      n_cmp = 0;
  int      n_bad = 0;
  bit      issued;
  int      n_wait;
  exp_t    q_a[$];
  exp_t    q_b[$];
  longint  m_acc [2];
  bit      m_first [2];
  bit      m_sticky [2];
  logic [PW-1:0] mul_pipe [LAT];

  always #5 CLK = ~CLK;

  mult_accum_stage #(.ACC_width(24)) dut_a (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_TC(in_TC),
    .in_ready(in_ready_a), .PRODUCT(PRODUCT), .ACC(acc_a), .ACC_ovf(ovf_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  mult_accum_stage #(.ACC_width(16)) dut_b (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_TC(in_TC),
    .in_ready(in_ready_b), .PRODUCT(PRODUCT), .ACC(acc_b), .ACC_ovf(ovf_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_first[i] = 1'b1; m_sticky[i] = 1'b0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  // One accepted beat, computed with plain integer arithmetic for each width.
  task automatic model_beat(input bit last, input bit tc, input logic [PW-1:0] prod);
    int     w;
    longint umax, hi, lo, a, e, s, r;
    bit     ovf;
    for (int i = 0; i < 2; i++) begin
      w    = (i == 0) ? 24 : 16;
      umax = (longint'(1) << w) - 1;
      hi   = (longint'(1) << (w - 1)) - 1;
      lo   = -(longint'(1) << (w - 1));
      if (m_first[i])          a = 0;
      else if (tc && m_acc[i] > hi) a = m_acc[i] - (umax + 1);
      else                     a = m_acc[i];
      e   = tc ? longint'($signed(prod)) : longint'(prod);
      s   = a + e;
      ovf = tc ? (s > hi || s < lo) : (s > umax);
`ifdef MULT_ACCUM_SAT_EN
      if (!ovf)    r = s;
      else if (tc) r = (s > hi) ? hi : lo;
      else         r = umax;
`else
      r = s;
`endif
      r = r & umax;
      m_sticky[i] = m_sticky[i] | ovf;
      if (last) begin
        if (i == 0) q_a.push_back('{acc: r, ovf: m_sticky[i]});
        else        q_b.push_back('{acc: r, ovf: m_sticky[i]});
        m_acc[i] = 0; m_first[i] = 1'b1; m_sticky[i] = 1'b0;
      end else begin
        m_acc[i] = r; m_first[i] = 1'b0;
      end
    end
  endtask

  // Called at a falling edge: drive one cycle, score any pop, return at the next falling edge.
  task automatic step(input bit v, input bit last, input bit tc, input logic [PW-1:0] prod,
                      input bit ordy);
    exp_t e;
    in_valid  = v;
    in_last   = last;
    in_TC     = tc;
    out_ready = ordy;
    issued    = v && in_ready_a;
    if (issued) model_beat(last, tc, prod);
    if (out_valid_a && ordy) begin
      check("a_expected_entry", (q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_acc", acc_a, e.acc);
        check("a_ovf", ovf_a, e.ovf);
      end
    end
    if (out_valid_b && ordy) begin
      check("b_expected_entry", (q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_acc", acc_b, e.acc);
        check("b_ovf", ovf_b, e.ovf);
      end
    end
    @(posedge CLK);
    #1;
    for (int i = LAT - 1; i > 0; i--) mul_pipe[i] = mul_pipe[i-1];
    mul_pipe[0] = prod;
    PRODUCT     = mul_pipe[LAT-1];
    @(negedge CLK);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 1'b0, PW'($urandom), ordy);
  endtask

  task automatic wait_out(input string tag);
    n_wait = 1;
    while (!out_valid_a && n_wait < 20) begin
      idle(1'b0);
      n_wait++;
    end
    check(tag, out_valid_a, 1);
  endtask

  task automatic drain(input string tag);
    repeat (10) idle(1'b1);
    check({tag, "_a_left"}, q_a.size(), 0);
    check({tag, "_b_left"}, q_b.size(), 0);
    check({tag, "_out_valid"}, out_valid_a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_iss;
    bit v, last, tc;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_TC = 1'b0; out_ready = 1'b0;
    PRODUCT = '0;
    for (int i = 0; i < LAT; i++) mul_pipe[i] = '0;
    model_clear();
    repeat (2) @(negedge CLK);
    check("rst_a_out_valid", out_valid_a, 0);
    check("rst_a_acc", acc_a, 0);
    check("rst_a_ovf", ovf_a, 0);
    check("rst_a_in_ready", in_ready_a, 1);
    check("rst_b_out_valid", out_valid_b, 0);
    check("rst_b_acc", acc_b, 0);
    check("rst_b_in_ready", in_ready_b, 1);
    rst_n = 1'b1;
    idle(1'b0);

    // Unsigned three-beat frame and its output latency.
    step(1'b1, 1'b0, 1'b0, 16'd10, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd20, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'd30, 1'b0);
    wait_out("t1_out_valid");
    check("t1_latency", n_wait, 4);
    check("t1_acc", acc_a, 60);
    check("t1_ovf", ovf_a, 0);
    drain("t1");

    // Signed frame: -10 + 5.
    step(1'b1, 1'b0, 1'b1, 16'hFFF6, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0005, 1'b0);
    wait_out("t2_out_valid");
    check("t2_acc_a", acc_a, 24'hFFFFFB);
    check("t2_acc_b", acc_b, 16'hFFFB);
    check("t2_ovf", ovf_a, 0);
    drain("t2");

    // Unsigned overflow: two beats of 0xFFFF.
    step(1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0);
    wait_out("t3_out_valid");
`ifdef MULT_ACCUM_SAT_EN
    check("t3_acc_b", acc_b, 16'hFFFF);
`else
    check("t3_acc_b", acc_b, 16'hFFFE);
`endif
    check("t3_ovf_b", ovf_b, 1);
    check("t3_acc_a", acc_a, 24'h01FFFE);
    check("t3_ovf_a", ovf_a, 0);
    drain("t3");

    // Backpressure: single-beat frames every cycle with the consumer stalled.
    n_iss = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0, PW'(100 + k), 1'b0);
      if (issued) n_iss++;
    end
    check("bp_issue_count", n_iss, 2);
    check("bp_out_valid", out_valid_a, 1);
    check("bp_in_ready_low", in_ready_a, 0);
    repeat (3) idle(1'b0);
    check("bp_hold_acc", acc_a, q_a[0].acc);
    check("bp_still_blocked", in_ready_a, 0);
    drain("bp");
    check("bp_in_ready_recovered", in_ready_a, 1);

    // Streaming with the consumer draining: pushes and pops overlap.
    for (int k = 0; k < 30; k++) begin
      step(1'b1, (k % 3) != 0, k[0], PW'($urandom), 1'b1);
    end
    drain("stream");

    // Reset with a buffered entry and two beats in flight.
    step(1'b1, 1'b1, 1'b0, 16'd55, 1'b0);
    wait_out("rst_setup_out_valid");
    step(1'b1, 1'b0, 1'b0, 16'd100, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd200, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_acc", acc_a, 0);
    check("midrst_ovf", ovf_a, 0);
    check("midrst_in_ready", in_ready_a, 1);
    model_clear();
    @(negedge CLK);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 16'd7, 1'b0);
    wait_out("post_rst_out_valid");
    check("post_rst_acc", acc_a, 7);
    drain("post_rst");

    // Randomised frames, signedness and consumer readiness.
    tc = 1'b0;
    for (int k = 0; k < 400; k++) begin
      v    = ($urandom_range(0, 3) != 0);
      last = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) tc = ~tc;
      step(v, last, tc, PW'($urandom), ($urandom_range(0, 2) != 0));
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
